// File: rtl/cordic_pkg.sv
// Shared angle constants, types and the saturating adder used by the
// CORDIC angle post-processing blocks.
package cordic_pkg;

  localparam int ANG_W_DEF   = 32;
  localparam int DELTA_W_DEF = 16;
  localparam int ANG_HALF    = 180;
  localparam int ANG_FULL    = 360;

  typedef logic signed [ANG_W_DEF-1:0]   angle_t;
  typedef logic signed [DELTA_W_DEF-1:0] delta_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_t;

  // Adds two sign-extended operands and clamps to a signed field of 'width' bits.
  function automatic sat_t sat_add(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int unsigned width);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_t r;
    s = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    r.ovf = 1'b0;
    r.val = s[63:0];
    if (s > hi) begin
      r.ovf = 1'b1;
      r.val = hi[63:0];
    end else if (s < lo) begin
      r.ovf = 1'b1;
      r.val = lo[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_avg_window.sv
// Moving average over the last 2^AVG_LOG2 phase steps, kept as a ring
// buffer plus running sum; valid only once the window has filled.
module phase_avg_window #(
  parameter int DELTA_W  = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      flush,
  input  logic signed [DELTA_W-1:0] din,
  output logic signed [DELTA_W-1:0] avg,
  output logic                      valid
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = DELTA_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FULL = {1'b1, {AVG_LOG2{1'b0}}};

  logic signed [DELTA_W-1:0] ring [N];
  logic [AVG_LOG2-1:0]       ptr;
  logic [AVG_LOG2:0]         count;
  logic [AVG_LOG2:0]         count_next;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   sum_next;

  // The slot under ptr holds the oldest delta (zero while still filling).
  always_comb begin
    sum_next   = sum + SUM_W'(din) - SUM_W'(ring[ptr]);
    count_next = (count == FULL) ? FULL : count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) ring[i] <= '0;
      ptr   <= '0;
      count <= '0;
      sum   <= '0;
      avg   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) ring[i] <= '0;
      ptr   <= '0;
      count <= '0;
      sum   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= push && (count_next == FULL);
      if (push) begin
        ring[ptr] <= din;
        ptr       <= ptr + 1'b1;
        count     <= count_next;
        sum       <= sum_next;
        avg       <= DELTA_W'(sum_next >>> AVG_LOG2);
      end
    end
  end

endmodule

// File: rtl/cordic_phase_unwrap.sv
// Unwraps the CORDIC per-sample angle into a continuous phase, and reports
// the wrapped phase step and its moving average. Two-stage pipeline.
module cordic_phase_unwrap
  import cordic_pkg::*;
#(
  parameter int ANG_W    = 32,
  parameter int DELTA_W  = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic signed [ANG_W-1:0]   angle_in,
  output logic                      out_valid,
  output logic signed [ANG_W-1:0]   phase_out,
  output logic signed [DELTA_W-1:0] delta_out,
  output logic                      avg_valid,
  output logic signed [DELTA_W-1:0] avg_out,
  output logic                      err_range,
  output logic                      err_ovf
);

  localparam logic signed [ANG_W:0] HALF = (ANG_W + 1)'(ANG_HALF);
  localparam logic signed [ANG_W:0] FULL = (ANG_W + 1)'(ANG_FULL);

  logic signed [ANG_W-1:0]   prev;
  logic                      first;
  logic signed [ANG_W:0]     angle_w;
  logic signed [ANG_W:0]     prev_w;
  logic signed [ANG_W:0]     d_raw;
  logic signed [ANG_W:0]     d_wrap;
  logic                      in_range;
  logic                      accept;
  logic                      first_eff;

  logic                      s1_valid;
  logic                      s1_first;
  logic signed [ANG_W-1:0]   s1_angle;
  logic signed [DELTA_W-1:0] s1_delta;
  logic                      push;
  sat_t                      acc_sum;

  // A clear in the same cycle as a sample makes that sample the first one.
  always_comb begin
    angle_w   = {angle_in[ANG_W-1], angle_in};
    prev_w    = {prev[ANG_W-1], prev};
    in_range  = (angle_w >= -HALF) && (angle_w <= HALF);
    accept    = in_valid && in_range;
    first_eff = first || clear;
    d_raw     = angle_w - prev_w;
    d_wrap    = d_raw;
    if (d_raw > HALF) begin
      d_wrap = d_raw - FULL;
    end else if (d_raw <= -HALF) begin
      d_wrap = d_raw + FULL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      first     <= 1'b1;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_angle  <= '0;
      s1_delta  <= '0;
      err_range <= 1'b0;
    end else begin
      if (in_valid && !in_range) err_range <= 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_first <= first_eff;
        s1_angle <= angle_in;
        s1_delta <= first_eff ? '0 : DELTA_W'(d_wrap);
        prev     <= angle_in;
        first    <= 1'b0;
      end else if (clear) begin
        first <= 1'b1;
      end
    end
  end

  always_comb begin
    acc_sum = sat_add(64'(phase_out), 64'(s1_delta), ANG_W);
    push    = s1_valid && !clear;
  end

  // Stage 2: a clear squashes the sample currently leaving stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      phase_out <= '0;
      delta_out <= '0;
      err_ovf   <= 1'b0;
    end else begin
      out_valid <= push;
      if (push) begin
        delta_out <= s1_delta;
        if (s1_first) begin
          phase_out <= s1_angle;
        end else begin
          phase_out <= ANG_W'(acc_sum.val);
          if (acc_sum.ovf) err_ovf <= 1'b1;
        end
      end
    end
  end

  phase_avg_window #(
    .DELTA_W (DELTA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_window (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .flush(clear),
    .din  (s1_delta),
    .avg  (avg_out),
    .valid(avg_valid)
  );

endmodule

// File: tb/tb_cordic_phase_unwrap.sv
// Directed plus randomized bench for cordic_phase_unwrap, checked against a
// cycle-level behavioural model of the unwrap/average rules.
module tb_cordic_phase_unwrap;
  import cordic_pkg::*;

  localparam int ANG_W    = 32;
  localparam int DELTA_W  = 16;
  localparam int AVG_LOG2 = 2;
  localparam int N        = 1 << AVG_LOG2;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   clear = 1'b0;
  logic   in_valid = 1'b0;
  angle_t angle_in = '0;
  logic   out_valid;
  angle_t phase_out;
  delta_t delta_out;
  logic   avg_valid;
  delta_t avg_out;
  logic   err_range;
  logic   err_ovf;

  int n_vec = 0;
  int n_err = 0;

  // Model state: unwrap history and the result waiting one stage in flight.
  bit     m_first;
  longint m_prev, m_phase;
  longint m_hist[$];
  bit     p_v, p_full, p_ovf;
  longint p_phase, p_delta, p_avg;
  bit     e_valid, e_avg_valid, e_range, e_ovf;
  longint e_phase, e_delta, e_avg;

  cordic_phase_unwrap #(
    .ANG_W(ANG_W), .DELTA_W(DELTA_W), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .angle_in(angle_in), .out_valid(out_valid), .phase_out(phase_out),
    .delta_out(delta_out), .avg_valid(avg_valid), .avg_out(avg_out),
    .err_range(err_range), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  function automatic longint floor_div(input longint s, input longint n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("phase_out", 64'(phase_out), e_phase);
    check("delta_out", 64'(delta_out), e_delta);
    check("avg_valid", 64'(avg_valid), 64'(e_avg_valid));
    check("avg_out",   64'(avg_out),   e_avg);
    check("err_range", 64'(err_range), 64'(e_range));
    check("err_ovf",   64'(err_ovf),   64'(e_ovf));
  endtask

  task automatic model_reset();
    m_first = 1'b1; m_prev = 0; m_phase = 0; m_hist.delete();
    p_v = 1'b0; p_full = 1'b0; p_ovf = 1'b0; p_phase = 0; p_delta = 0; p_avg = 0;
    e_valid = 1'b0; e_avg_valid = 1'b0; e_range = 1'b0; e_ovf = 1'b0;
    e_phase = 0; e_delta = 0; e_avg = 0;
  endtask

  task automatic model_cycle(input bit v, input int a, input bit c);
    longint d, ph, s, hi, lo;
    e_valid = 1'b0;
    e_avg_valid = 1'b0;
    if (p_v && !c) begin
      e_valid = 1'b1; e_phase = p_phase; e_delta = p_delta;
      e_avg = p_avg; e_avg_valid = p_full;
      if (p_ovf) e_ovf = 1'b1;
    end
    p_v = 1'b0;
    if (c) begin
      m_first = 1'b1;
      m_hist.delete();
    end
    if (v) begin
      if (a < -180 || a > 180) begin
        e_range = 1'b1;
      end else begin
        hi = (longint'(1) <<< (ANG_W - 1)) - 1;
        lo = -hi - 1;
        p_ovf = 1'b0;
        if (m_first) begin
          d = 0; ph = a;
        end else begin
          d = a - m_prev;
          if (d > 180) d -= 360;
          else if (d <= -180) d += 360;
          ph = m_phase + d;
          if (ph > hi) begin ph = hi; p_ovf = 1'b1; end
          if (ph < lo) begin ph = lo; p_ovf = 1'b1; end
        end
        m_first = 1'b0; m_prev = a; m_phase = ph;
        m_hist.push_back(d);
        if (m_hist.size() > N) void'(m_hist.pop_front());
        s = 0;
        foreach (m_hist[i]) s += m_hist[i];
        p_v = 1'b1; p_phase = ph; p_delta = d;
        p_avg = floor_div(s, N);
        p_full = (m_hist.size() >= N);
      end
    end
  endtask

  task automatic step(input bit v, input int a, input bit c);
    in_valid = v;
    angle_in = a;
    clear = c;
    model_cycle(v, a, c);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    clear = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int a;
    apply_reset();
    step(1, 10, 0); step(1, 20, 0); step(1, 30, 0);
    step(0, 0, 0); step(0, 0, 0);
    check("phase_held_30", 64'(phase_out), 64'sd30);

    step(0, 0, 1);
    step(1, 170, 0); step(1, -170, 0); step(1, -150, 0); step(0, 0, 0);
    step(0, 0, 1);
    step(1, -170, 0); step(1, 170, 0); step(0, 0, 0); step(0, 0, 0);
    check("phase_reverse", 64'(phase_out), -64'sd190);

    step(0, 0, 1);
    step(1, 0, 0); step(1, 180, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    check("phase_half_turns", 64'(phase_out), 64'sd360);

    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 5 * i, 0);
    step(0, 0, 0); step(0, 0, 0);

    step(1, 100, 0); step(1, 200, 0); step(1, 130, 0);
    step(0, 0, 0); step(0, 0, 0);
    check("delta_after_drop", 64'(delta_out), 64'sd30);

    step(0, 0, 1);
    step(1, 0, 0); step(1, 180, 0); step(1, 0, 0); step(1, 180, 0); step(1, 0, 0);
    step(0, 0, 0);
    step(1, 45, 1); step(0, 0, 0); step(0, 0, 0);
    check("phase_after_clear", 64'(phase_out), 64'sd45);

    step(1, 10, 0); step(1, 20, 0);
    apply_reset();
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 360)) - 180;
      if ($urandom_range(0, 15) == 0)
        a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(181, 400))
                                        : -int'($urandom_range(181, 400));
      step($urandom_range(0, 7) != 0, a, $urandom_range(0, 19) == 0);
    end
    step(0, 0, 0); step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
